// File: rtl/nrisc_fetch_unit.sv
// NRISC instruction-fetch stage: owns the PC and the return-address stack, fetches
// 16-bit words over a req/ack handshake and hands them to the control unit.
module nrisc_fetch_unit #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        FETCH_PC_ctrl,
  input  logic              FETCH_PC_step,
  input  logic              FETCH_STACK_push,
  input  logic [ADDR_W-1:0] FETCH_jump_addr,
  output logic [ADDR_W-1:0] IMEM_addr,
  output logic              IMEM_req,
  input  logic              IMEM_ack,
  input  logic [15:0]       IMEM_data,
  output logic [15:0]       FETCH_InstructionOUT,
  output logic              FETCH_valid,
  output logic [ADDR_W-1:0] FETCH_PC,
  output logic              FETCH_stack_overflow,
  output logic              FETCH_stack_underflow
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned INSN_W = 16;

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(STACK_DEPTH);

  localparam logic [1:0] CTRL_NEXT = 2'd0;
  localparam logic [1:0] CTRL_HOLD = 2'd1;
  localparam logic [1:0] CTRL_JUMP = 2'd2;
  localparam logic [1:0] CTRL_RET  = 2'd3;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                req_q, req_d;
  logic                valid_q, valid_d;
  logic [INSN_W-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0]   stack_d [STACK_DEPTH];

  logic [ADDR_W-1:0]   pc_inc;
  logic [PTR_W-1:0]    push_idx;
  logic [PTR_W-1:0]    pop_idx;
  logic                refetch;

  // Next-state, datapath and stack update
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    valid_d  = valid_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    stack_d  = stack_q;
    refetch  = 1'b0;
    pc_inc   = pc_q + ADDR_W'(1);
    push_idx = cnt_q[PTR_W-1:0];
    pop_idx  = PTR_W'(cnt_q - CNT_W'(1));

    unique case (state_q)
      ST_FETCH: begin
        // req_q gates the ack so a response straggling in across reset is dropped
        if (req_q && IMEM_ack) begin
          ir_d    = IMEM_data;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = ST_READY;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_READY: begin
        if (FETCH_PC_step) begin
          unique case (FETCH_PC_ctrl)
            CTRL_NEXT: begin
              pc_d    = pc_inc;
              refetch = 1'b1;
            end
            CTRL_HOLD: begin
              pc_d = pc_q;
            end
            CTRL_JUMP: begin
              if (FETCH_STACK_push) begin
                if (cnt_q < FULL_CNT) begin
                  stack_d[push_idx] = pc_inc;
                  cnt_d             = cnt_q + CNT_W'(1);
                end else begin
                  ovf_d = 1'b1;
                end
              end
              pc_d    = FETCH_jump_addr;
              refetch = 1'b1;
            end
            CTRL_RET: begin
              if (cnt_q != '0) begin
                pc_d  = stack_q[pop_idx];
                cnt_d = cnt_q - CNT_W'(1);
              end else begin
                unf_d = 1'b1;
              end
              refetch = 1'b1;
            end
            default: begin
              pc_d = pc_q;
            end
          endcase
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (refetch) begin
      state_d = ST_FETCH;
      valid_d = 1'b0;
      req_d   = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_ADDR;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      ir_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  assign IMEM_addr             = pc_q;
  assign IMEM_req              = req_q;
  assign FETCH_PC              = pc_q;
  assign FETCH_InstructionOUT  = ir_q;
  assign FETCH_valid           = valid_q;
  assign FETCH_stack_overflow  = ovf_q;
  assign FETCH_stack_underflow = unf_q;

endmodule

// File: tb/tb_nrisc_fetch_unit.sv
// Bench for nrisc_fetch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized stepping.
module tb_nrisc_fetch_unit;

  localparam int unsigned DEPTH = 8;

  logic        clk;
  logic        rst;
  logic [1:0]  ctrl;
  logic        step;
  logic        push;
  logic [15:0] jaddr;
  logic [15:0] IMEM_addr;
  logic        IMEM_req;
  logic        IMEM_ack;
  logic [15:0] IMEM_data;
  logic [15:0] ir;
  logic        valid;
  logic [15:0] pc;
  logic        ovf;
  logic        unf;

  int n_checks;
  int n_pass;

  // memory-side knobs
  int          wait_target;
  int          wcnt;
  logic [15:0] salt;
  bit          force_ack;

  nrisc_fetch_unit #(.ADDR_W(16), .STACK_DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .FETCH_PC_ctrl         (ctrl),
    .FETCH_PC_step         (step),
    .FETCH_STACK_push      (push),
    .FETCH_jump_addr       (jaddr),
    .IMEM_addr             (IMEM_addr),
    .IMEM_req              (IMEM_req),
    .IMEM_ack              (IMEM_ack),
    .IMEM_data             (IMEM_data),
    .FETCH_InstructionOUT  (ir),
    .FETCH_valid           (valid),
    .FETCH_PC              (pc),
    .FETCH_stack_overflow  (ovf),
    .FETCH_stack_underflow (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: one fetched word outstanding at a time, stack as a queue
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  bit          m_req, m_valid, m_ready, m_ovf, m_unf;
  logic [15:0] m_stack[$];

  always @(posedge clk or negedge rst) begin
    bit go;
    go = 1'b0;
    if (!rst) begin
      m_pc = 16'h0000; m_ir = 16'h0000;
      m_req = 0; m_valid = 0; m_ready = 0; m_ovf = 0; m_unf = 0;
      m_stack.delete();
    end else if (!m_ready) begin
      if (m_req && IMEM_ack) begin
        m_ir = IMEM_data; m_valid = 1; m_req = 0; m_ready = 1;
      end else begin
        m_req = 1;
      end
    end else if (step) begin
      case (ctrl)
        2'd0: begin m_pc = m_pc + 16'd1; go = 1; end
        2'd1: go = 0;
        2'd2: begin
          if (push) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(m_pc + 16'd1);
            else m_ovf = 1;
          end
          m_pc = jaddr; go = 1;
        end
        default: begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else m_unf = 1;
          go = 1;
        end
      endcase
      if (go) begin m_ready = 0; m_valid = 0; m_req = 1; end
    end
  end

  // Compare every cycle away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      check("imem_req", IMEM_req, m_req);
      check("imem_addr", IMEM_addr, m_pc);
      check("fetch_pc", pc, m_pc);
      check("valid", valid, m_valid);
      check("ir", ir, m_ir);
      check("overflow", ovf, m_ovf);
      check("underflow", unf, m_unf);
    end
  end

  // Instruction memory with programmable wait states
  always @(negedge clk) begin
    if (force_ack) begin
      IMEM_ack  = 1'b1;
      IMEM_data = 16'hDEAD;
    end else if (IMEM_req) begin
      if (wcnt >= wait_target) begin
        IMEM_ack  = 1'b1;
        IMEM_data = IMEM_addr ^ salt;
      end else begin
        IMEM_ack = 1'b0;
        wcnt++;
      end
    end else begin
      IMEM_ack = 1'b0;
      wcnt     = 0;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      n_checks++;
      $display("FAIL wait_ready: valid=0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic do_step(input logic [1:0] c, input logic p, input logic [15:0] j);
    wait_ready();
    ctrl = c; push = p; jaddr = j; step = 1'b1;
    @(negedge clk);
    step = 1'b0; push = 1'b0;
  endtask

  function automatic logic [15:0] call_site(input int k);
    return (k == 0) ? 16'h0011 : 16'(16'h0200 + 16 * (k - 1));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req;
    n_checks = 0; n_pass = 0;
    rst = 1'b0; ctrl = 2'd0; step = 1'b0; push = 1'b0; jaddr = 16'h0;
    IMEM_ack = 1'b0; IMEM_data = 16'h0;
    wait_target = 0; wcnt = 0; salt = 16'h0; force_ack = 0;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_req", IMEM_req, 0);
    check("rst_valid", valid, 0);
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    @(negedge clk);
    check("first_req", IMEM_req, 1);
    check("first_addr", IMEM_addr, 0);

    // Sequential fetch, zero wait states
    wait_ready();
    check("seq_ir0", ir, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      do_step(2'd0, 1'b0, 16'h0);
      check("seq_addr", IMEM_addr, i);
      check("seq_valid_drop", valid, 0);
      @(negedge clk);
      check("seq_valid_back", valid, 1);
      check("seq_ir", ir, i);
    end

    // Three wait states, with a step pulse during the fetch that must be ignored
    wait_target = 3;
    do_step(2'd0, 1'b0, 16'h0);
    n_req = 0;
    for (int k = 0; k < 20 && !valid; k++) begin
      if (IMEM_req) n_req++;
      ctrl = 2'd0;
      step = (n_req == 2);
      @(negedge clk);
    end
    step = 1'b0;
    check("wait_req_cycles", n_req, 4);
    check("wait_pc", pc, 16'h0004);
    check("wait_ir", ir, 16'h0004);

    // Hold: no memory access, valid stays
    do_step(2'd1, 1'b0, 16'h0);
    check("hold_req", IMEM_req, 0);
    check("hold_valid", valid, 1);
    check("hold_pc", pc, 16'h0004);
    wait_target = 0;

    // Call / return
    do_step(2'd2, 1'b0, 16'h0010);
    check("jump_addr", IMEM_addr, 16'h0010);
    do_step(2'd2, 1'b1, 16'h0100);
    check("call_addr", IMEM_addr, 16'h0100);
    do_step(2'd0, 1'b0, 16'h0);
    do_step(2'd3, 1'b0, 16'h0);
    check("ret_addr", IMEM_addr, 16'h0011);

    // Fill the stack past its depth, then unwind past empty
    for (int i = 0; i <= 8; i++) begin
      do_step(2'd2, 1'b1, 16'(16'h0200 + 16 * i));
      check("call_n_addr", IMEM_addr, 16'h0200 + 16 * i);
      check("call_n_ovf", ovf, (i == 8) ? 1 : 0);
    end
    for (int j = 0; j < 8; j++) begin
      do_step(2'd3, 1'b0, 16'h0);
      check("ret_n_addr", IMEM_addr, 16'(call_site(7 - j) + 16'd1));
      check("ret_n_unf", unf, 0);
    end
    do_step(2'd3, 1'b0, 16'h0);
    check("underflow_set", unf, 1);
    check("underflow_refetch", IMEM_addr, 16'h0012);
    check("underflow_req", IMEM_req, 1);

    // PC wrap
    do_step(2'd2, 1'b0, 16'hFFFF);
    check("wrap_pre", IMEM_addr, 16'hFFFF);
    do_step(2'd0, 1'b0, 16'h0);
    check("wrap_addr", IMEM_addr, 16'h0000);

    // Randomized stepping with random wait states and data salt
    for (int it = 0; it < 400; it++) begin
      wait_target = $urandom_range(0, 3);
      salt = 16'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_step(2'($urandom_range(0, 3)), 1'($urandom), 16'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        ctrl = 2'($urandom); push = 1'($urandom); step = 1'b1;
        @(negedge clk);
        step = 1'b0; push = 1'b0;
      end
    end

    // Async reset during an outstanding fetch; ack arriving in reset is dropped
    wait_target = 20;
    do_step(2'd0, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    check("pre_reset_req", IMEM_req, 1);
    #2 rst = 1'b0;
    #1;
    check("async_req_drop", IMEM_req, 0);
    check("async_valid", valid, 0);
    check("async_pc", pc, 16'h0000);
    check("async_ovf", ovf, 0);
    @(negedge clk);
    #1 force_ack = 1;
    @(negedge clk);
    @(negedge clk);
    #1 wait_target = 0; force_ack = 0; salt = 16'h5A5A;
    #1 rst = 1'b1;
    @(negedge clk);
    check("late_ack_ir", ir, 16'h0000);
    check("late_ack_valid", valid, 0);
    check("post_rst_req", IMEM_req, 1);
    check("post_rst_addr", IMEM_addr, 16'h0000);
    wait_ready();
    check("post_rst_ir", ir, 16'h5A5A);
    for (int it = 0; it < 20; it++) begin
      do_step(2'($urandom_range(0, 3)), 1'($urandom), 16'($urandom));
    end
    wait_ready();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
